amba3_axi_burst_addr_gen: RTL and testbench
===========================================

Name: amba3_axi_burst_addr_gen

Overview:
- Per-beat address/strobe generator for the AXI3 slave datapath.
- Sits directly downstream of the AW/AR channel capture in the slave, and upstream of the W-data write and R-data read engines.
- Accepts one burst command (addr, len, size, burst) and emits one beat descriptor per transfer: address, byte-lane strobe, beat index, last flag.
- FIXED, INCR and WRAP are expanded exactly as the VIP transaction classes expand them.

Parameters:
ADDR_SIZE, 32, address width in bits
DATA_SIZE, 128, data bus width in bits; power of two, 8..1024; DBYTES = DATA_SIZE/8

Ports:
aclk  in  1  clock
areset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  burst command valid
cmd_ready  out  1  burst command accepted when valid&ready
cmd_addr  in  ADDR_SIZE  start address (AxADDR)
cmd_len  in  4  beats minus one (AxLEN)
cmd_size  in  3  log2 bytes per beat (AxSIZE)
cmd_burst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
beat_valid  out  1  beat descriptor valid
beat_ready  in  1  consumer accepts beat
beat_addr  out  ADDR_SIZE  address of this beat
beat_strb  out  DBYTES  active byte lanes on the data bus
beat_idx  out  4  beat number, 0..len
beat_last  out  1  final beat of burst
beat_err  out  1  command was illegal; constant for all beats of the burst

Behaviour:
- Reset: asynchronous on areset_n low.
  - Reset values: state=IDLE, cmd_ready=1, beat_valid=0, beat_addr=0, beat_strb=0, beat_idx=0, beat_last=0, beat_err=0.
  - Reset mid-burst abandons the burst immediately; no further beats are emitted.
- States:
  - IDLE -> BUSY on cmd_valid&cmd_ready.
  - BUSY -> IDLE on a last-beat handshake when no new command is accepted in the same cycle.
  - BUSY -> BUSY on a last-beat handshake together with a command accept (back-to-back).
- cmd_ready = (state==IDLE) | (beat_valid & beat_ready & beat_last).
- Latency: beat 0 is valid the cycle after command accept. Back-to-back bursts have zero bubble.
- Handshake: a beat advances only on beat_valid&beat_ready. All beat_* outputs stay stable while beat_valid&!beat_ready.
- Command decode (registered at accept):
  - nbytes = 1<<size.
  - aligned = addr & ~(nbytes-1).
  - beat_err=1 if any of:
    - size > log2(DBYTES);
    - burst==11;
    - burst==WRAP and (len not in {1,3,7,15} or addr != aligned).
  - When beat_err=1: size is clamped to log2(DBYTES), and a reserved or illegal WRAP burst is expanded as INCR. Beats are still emitted so the slave can return SLVERR with the correct beat count.
- Address sequence (beat 0 always = cmd_addr):
  - FIXED: every beat = cmd_addr.
  - INCR: beat n = aligned + n*nbytes for n>=1. Address wraps modulo 2^ADDR_SIZE; 4KB crossing is not checked.
  - WRAP:
    - wsize = (len+1)*nbytes; lower = addr & ~(wsize-1).
    - next = cur+nbytes; when next == lower+wsize, next = lower.
- Strobe per beat, with lane = beat_addr mod DBYTES and lo = lane, hi = (lane | (nbytes-1) mod DBYTES), bits lo..hi set:
  - Beat 0 and every FIXED beat: covers only bytes from the unaligned start up to the next size boundary.
  - Later INCR/WRAP beats: aligned, so exactly nbytes lanes.
- beat_idx counts 0..len. beat_last = (beat_idx==len). len=0 gives a single beat with beat_last=1.
- Single register stage; no combinational path from cmd_* to beat_*. cmd_ready depends combinationally on beat_ready.

Test Plan:
- INCR addr=0x104 size=2 len=3, beat_ready=1:
  - beats 0x104/0x00f0, 0x108/0x0f00, 0x10C/0xf000, 0x110/0x000f;
  - last on idx 3; beat_valid one cycle after accept.
- INCR unaligned addr=0x201 size=3 len=2: strb 0x00fe, 0xff00, 0x00ff; addrs 0x201, 0x208, 0x210.
- WRAP addr=0x21C size=1 len=3:
  - addrs 0x21C, 0x21E, 0x218, 0x21A;
  - strb 0x3000, 0xC000, 0x0300, 0x0C00; beat_err=0.
- FIXED addr=0x106 size=0 len=4 with random beat_ready stalls:
  - five beats, all addr 0x106 / strb 0x0040;
  - outputs held stable during stalls; last on idx 4.
- Illegal commands:
  - WRAP len=2 -> beat_err=1, INCR sequence of 3 beats;
  - burst=11 -> beat_err=1;
  - size=5 on a 128-bit bus -> clamped to 16-byte beats with beat_err=1.
- Back-to-back and reset:
  - second command held valid during the first burst is accepted on the last-beat handshake, and its beat 0 appears the next cycle with no bubble;
  - areset_n pulsed low mid-burst -> beat_valid=0 immediately, cmd_ready=1, IDLE.

Source files
------------

// File: rtl/amba3_axi_burst_addr_gen_if.sv
// Command and beat-descriptor bundle between AXI3 channel capture and the
// slave data engines.
interface amba3_axi_burst_addr_gen_if #(
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 128
);
  localparam int DBYTES = DATA_SIZE / 8;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [ADDR_SIZE-1:0] cmd_addr;
  logic [3:0]           cmd_len;
  logic [2:0]           cmd_size;
  logic [1:0]           cmd_burst;

  logic                 beat_valid;
  logic                 beat_ready;
  logic [ADDR_SIZE-1:0] beat_addr;
  logic [DBYTES-1:0]    beat_strb;
  logic [3:0]           beat_idx;
  logic                 beat_last;
  logic                 beat_err;

  modport master (
    output cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
    input  cmd_ready, beat_valid, beat_addr, beat_strb, beat_idx, beat_last, beat_err
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
    output cmd_ready, beat_valid, beat_addr, beat_strb, beat_idx, beat_last, beat_err
  );
endinterface

// File: rtl/amba3_axi_burst_addr_gen.sv
// Expands one AXI3 burst command (FIXED/INCR/WRAP) into per-beat address,
// byte-lane strobe, index and last descriptors; illegal commands are flagged.
module amba3_axi_burst_addr_gen #(
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 128
) (
  input logic                        aclk,
  input logic                        areset_n,
  amba3_axi_burst_addr_gen_if.slave  bus
);
  localparam int DBYTES  = DATA_SIZE / 8;
  localparam int LOG2_DB = $clog2(DBYTES);
  localparam logic [2:0]           MAX_SIZE  = 3'(LOG2_DB);
  localparam logic [ADDR_SIZE-1:0] LANE_MASK = ADDR_SIZE'(DBYTES - 1);
  localparam logic [ADDR_SIZE-1:0] ONE       = ADDR_SIZE'(1);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {MODE_FIXED = 2'b00, MODE_INCR = 2'b01, MODE_WRAP = 2'b10} mode_t;

  state_t               state_reg;
  mode_t                mode_reg;
  logic [2:0]           size_reg;
  logic [3:0]           len_reg;
  logic [ADDR_SIZE-1:0] wmask_reg;
  logic                 valid_reg;
  logic [ADDR_SIZE-1:0] addr_reg;
  logic [DBYTES-1:0]    strb_reg;
  logic [3:0]           idx_reg;
  logic                 last_reg;
  logic                 err_reg;

  logic                 cmd_ready_int;
  logic                 cmd_fire;
  logic                 beat_fire;
  logic [2:0]           cmd_size_clamp;
  logic [ADDR_SIZE-1:0] cmd_nb_mask;
  logic                 cmd_len_ok;
  logic                 cmd_unaligned;
  logic                 cmd_err;
  mode_t                cmd_mode;
  logic [ADDR_SIZE-1:0] cmd_wmask;
  logic [ADDR_SIZE-1:0] cur_nb;
  logic [ADDR_SIZE-1:0] adv_addr;
  logic [ADDR_SIZE-1:0] addr_next;
  logic [2:0]           size_next;
  logic [ADDR_SIZE-1:0] size_mask_next;
  logic [ADDR_SIZE-1:0] lane_lo;
  logic [DBYTES-1:0]    strb_next;

  assign beat_fire     = valid_reg & bus.beat_ready;
  assign cmd_ready_int = (state_reg == IDLE) | (beat_fire & last_reg);
  assign cmd_fire      = bus.cmd_valid & cmd_ready_int;

  always_comb begin
    cmd_size_clamp = (bus.cmd_size > MAX_SIZE) ? MAX_SIZE : bus.cmd_size;
    cmd_nb_mask    = (ONE << cmd_size_clamp) - ONE;
    cmd_len_ok     = (bus.cmd_len == 4'd1) | (bus.cmd_len == 4'd3) |
                     (bus.cmd_len == 4'd7) | (bus.cmd_len == 4'd15);
    cmd_unaligned  = |(bus.cmd_addr & cmd_nb_mask);
    cmd_err        = (bus.cmd_size > MAX_SIZE) | (bus.cmd_burst == 2'b11) |
                     ((bus.cmd_burst == 2'b10) & (~cmd_len_ok | cmd_unaligned));
    cmd_wmask      = ((ADDR_SIZE'(bus.cmd_len) + ONE) << cmd_size_clamp) - ONE;
    // Any errored WRAP and the reserved encoding fall back to INCR expansion.
    case (bus.cmd_burst)
      2'b00:   cmd_mode = MODE_FIXED;
      2'b10:   cmd_mode = cmd_err ? MODE_INCR : MODE_WRAP;
      default: cmd_mode = MODE_INCR;
    endcase
  end

  always_comb begin
    cur_nb = ONE << size_reg;
    case (mode_reg)
      MODE_FIXED: adv_addr = addr_reg;
      MODE_WRAP:  adv_addr = (addr_reg & ~wmask_reg) | ((addr_reg + cur_nb) & wmask_reg);
      default:    adv_addr = (addr_reg & ~(cur_nb - ONE)) + cur_nb;
    endcase
    addr_next      = cmd_fire ? bus.cmd_addr : adv_addr;
    size_next      = cmd_fire ? cmd_size_clamp : size_reg;
    size_mask_next = (ONE << size_next) - ONE;
    lane_lo        = addr_next & LANE_MASK;
  end

  // A lane is active when it shares the size-aligned block of the start lane
  // and sits at or above it; this also trims an unaligned first beat.
  for (genvar gi = 0; gi < DBYTES; gi++) begin : g_strb
    assign strb_next[gi] =
      ((ADDR_SIZE'(gi) & ~size_mask_next) == (lane_lo & ~size_mask_next)) &&
      (ADDR_SIZE'(gi) >= lane_lo);
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_reg <= IDLE;
      mode_reg  <= MODE_FIXED;
      size_reg  <= 3'd0;
      len_reg   <= 4'd0;
      wmask_reg <= '0;
      valid_reg <= 1'b0;
      addr_reg  <= '0;
      strb_reg  <= '0;
      idx_reg   <= 4'd0;
      last_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else if (cmd_fire) begin
      state_reg <= BUSY;
      mode_reg  <= cmd_mode;
      size_reg  <= cmd_size_clamp;
      len_reg   <= bus.cmd_len;
      wmask_reg <= cmd_wmask;
      valid_reg <= 1'b1;
      addr_reg  <= addr_next;
      strb_reg  <= strb_next;
      idx_reg   <= 4'd0;
      last_reg  <= (bus.cmd_len == 4'd0);
      err_reg   <= cmd_err;
    end else if (beat_fire) begin
      if (last_reg) begin
        state_reg <= IDLE;
        valid_reg <= 1'b0;
      end else begin
        addr_reg <= addr_next;
        strb_reg <= strb_next;
        idx_reg  <= idx_reg + 4'd1;
        last_reg <= ((idx_reg + 4'd1) == len_reg);
      end
    end
  end

  assign bus.cmd_ready  = cmd_ready_int;
  assign bus.beat_valid = valid_reg;
  assign bus.beat_addr  = addr_reg;
  assign bus.beat_strb  = strb_reg;
  assign bus.beat_idx   = idx_reg;
  assign bus.beat_last  = last_reg;
  assign bus.beat_err   = err_reg;
endmodule

// File: tb/tb_amba3_axi_burst_addr_gen.sv
// Scoreboard bench for amba3_axi_burst_addr_gen: directed test-plan bursts,
// back-to-back, mid-burst reset and randomized commands against a beat model.
module tb_amba3_axi_burst_addr_gen;
  localparam int ADDR_SIZE = 32;
  localparam int DATA_SIZE = 128;
  localparam int DBYTES    = DATA_SIZE / 8;
  localparam int LOG2_DB   = 4;

  typedef struct {
    logic [31:0]       addr;
    logic [DBYTES-1:0] strb;
    logic [3:0]        idx;
    logic              last;
    logic              err;
  } beat_t;

  logic aclk = 1'b0;
  logic areset_n;
  int   checks = 0;
  int   errors = 0;
  bit   stall_en = 1'b0;
  bit   expect_v = 1'b0;
  beat_t exp_q[$];
  beat_t mon_e;

  amba3_axi_burst_addr_gen_if #(.ADDR_SIZE(ADDR_SIZE), .DATA_SIZE(DATA_SIZE)) bus_if ();

  amba3_axi_burst_addr_gen #(.ADDR_SIZE(ADDR_SIZE), .DATA_SIZE(DATA_SIZE)) dut (
    .aclk     (aclk),
    .areset_n (areset_n),
    .bus      (bus_if)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference expansion computed straight from the burst rules.
  function automatic void model_push(input logic [31:0] a, input logic [3:0] l,
                                     input logic [2:0] s, input logic [1:0] b);
    int     es;
    int     mode;
    int     lane;
    int     hi;
    longint nb, wsize, lower, cur, base, aa;
    bit     err;
    beat_t  e;
    aa    = longint'(a);
    es    = (int'(s) > LOG2_DB) ? LOG2_DB : int'(s);
    nb    = longint'(1) << es;
    err   = (int'(s) > LOG2_DB) || (b == 2'b11) ||
            ((b == 2'b10) && !((l == 1) || (l == 3) || (l == 7) || (l == 15))) ||
            ((b == 2'b10) && ((aa % nb) != 0));
    mode  = int'(b);
    if (err && mode >= 2) mode = 1;
    wsize = (longint'(l) + 1) * nb;
    lower = aa - (aa % wsize);
    base  = aa - (aa % nb);
    cur   = aa;
    for (int n = 0; n <= int'(l); n++) begin
      if (n > 0) begin
        if (mode == 0) cur = aa;
        else if (mode == 1) cur = base + longint'(n) * nb;
        else begin
          cur = cur + nb;
          if (cur == lower + wsize) cur = lower;
        end
      end
      lane = int'(cur % DBYTES);
      hi   = int'((longint'(lane) | (nb - 1)) % DBYTES);
      e.strb = '0;
      for (int i = lane; i <= hi; i++) e.strb[i] = 1'b1;
      e.addr = cur[31:0];
      e.idx  = 4'(n);
      e.last = (n == int'(l));
      e.err  = err;
      exp_q.push_back(e);
    end
  endfunction

  // Monitor / scoreboard, sampling on the falling edge.
  always @(negedge aclk) begin
    if (!areset_n) begin
      exp_q.delete();
      expect_v = 1'b0;
    end else begin
      if (expect_v) begin
        chk("beat0_latency", {63'd0, bus_if.beat_valid}, 64'd1);
        expect_v = 1'b0;
      end
      if (bus_if.beat_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got addr=0x%08h idx=%0d, required no beat",
                   bus_if.beat_addr, bus_if.beat_idx);
        end else begin
          mon_e = exp_q[0];
          checks++;
          if (bus_if.beat_addr !== mon_e.addr || bus_if.beat_strb !== mon_e.strb ||
              bus_if.beat_idx !== mon_e.idx || bus_if.beat_last !== mon_e.last ||
              bus_if.beat_err !== mon_e.err) begin
            errors++;
            $display("FAIL beat: got addr=0x%08h strb=0x%04h idx=%0d last=%0b err=%0b, required addr=0x%08h strb=0x%04h idx=%0d last=%0b err=%0b",
                     bus_if.beat_addr, bus_if.beat_strb, bus_if.beat_idx, bus_if.beat_last,
                     bus_if.beat_err, mon_e.addr, mon_e.strb, mon_e.idx, mon_e.last, mon_e.err);
          end
          if (bus_if.beat_ready) begin
            $display("beat addr=0x%08h strb=0x%04h idx=%0d last=%0b err=%0b",
                     bus_if.beat_addr, bus_if.beat_strb, bus_if.beat_idx,
                     bus_if.beat_last, bus_if.beat_err);
            void'(exp_q.pop_front());
          end
        end
      end
      if (bus_if.cmd_valid && bus_if.cmd_ready) begin
        $display("cmd  addr=0x%08h len=%0d size=%0d burst=%0d",
                 bus_if.cmd_addr, bus_if.cmd_len, bus_if.cmd_size, bus_if.cmd_burst);
        model_push(bus_if.cmd_addr, bus_if.cmd_len, bus_if.cmd_size, bus_if.cmd_burst);
        expect_v = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge aclk);
      #1;
      bus_if.beat_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input logic [31:0] a, input logic [3:0] l,
                      input logic [2:0] s, input logic [1:0] b);
    int cyc;
    bit done;
    bus_if.cmd_addr  = a;
    bus_if.cmd_len   = l;
    bus_if.cmd_size  = s;
    bus_if.cmd_burst = b;
    bus_if.cmd_valid = 1'b1;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 500) begin
      @(negedge aclk);
      if (bus_if.cmd_ready) done = 1'b1;
      else cyc++;
    end
    chk("cmd_accept", {63'd0, done}, 64'd1);
    @(posedge aclk);
    #1;
    bus_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int cyc;
    bit done;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 3000) begin
      @(negedge aclk);
      #1;
      if (!bus_if.beat_valid && exp_q.size() == 0) done = 1'b1;
      else cyc++;
    end
    chk("drain", {63'd0, done}, 64'd1);
    @(posedge aclk);
    #1;
  endtask

  initial begin
    logic [31:0] ra;
    logic [3:0]  rl;
    logic [2:0]  rs;
    logic [1:0]  rb;
    int          pick;
    areset_n          = 1'b0;
    bus_if.cmd_valid  = 1'b0;
    bus_if.cmd_addr   = '0;
    bus_if.cmd_len    = '0;
    bus_if.cmd_size   = '0;
    bus_if.cmd_burst  = '0;
    bus_if.beat_ready = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_cmd_ready",  {63'd0, bus_if.cmd_ready}, 64'd1);
    chk("rst_beat_valid", {63'd0, bus_if.beat_valid}, 64'd0);
    chk("rst_beat_addr",  {32'd0, bus_if.beat_addr}, 64'd0);
    chk("rst_beat_strb",  {48'd0, bus_if.beat_strb}, 64'd0);
    chk("rst_beat_idx",   {60'd0, bus_if.beat_idx}, 64'd0);
    chk("rst_beat_last",  {63'd0, bus_if.beat_last}, 64'd0);
    chk("rst_beat_err",   {63'd0, bus_if.beat_err}, 64'd0);
    areset_n = 1'b1;
    @(posedge aclk);
    #1;

    send(32'h104, 4'd3, 3'd2, 2'b01); wait_idle();
    send(32'h201, 4'd2, 3'd3, 2'b01); wait_idle();
    send(32'h21C, 4'd3, 3'd1, 2'b10); wait_idle();
    stall_en = 1'b1;
    send(32'h106, 4'd4, 3'd0, 2'b00); wait_idle();
    stall_en = 1'b0;
    send(32'h300, 4'd2, 3'd2, 2'b10); wait_idle();
    send(32'h040, 4'd1, 3'd2, 2'b11); wait_idle();
    send(32'h500, 4'd2, 3'd5, 2'b01); wait_idle();
    send(32'hFFFF_FFF8, 4'd3, 3'd3, 2'b01); wait_idle();
    send(32'hFFFF_FFF0, 4'd3, 3'd2, 2'b10); wait_idle();

    send(32'h1000, 4'd3, 3'd2, 2'b01);
    send(32'h2004, 4'd2, 3'd2, 2'b01);
    wait_idle();
    stall_en = 1'b1;
    send(32'h3000, 4'd1, 3'd4, 2'b10);
    send(32'h3101, 4'd0, 3'd1, 2'b00);
    send(32'h3200, 4'd7, 3'd0, 2'b10);
    wait_idle();
    stall_en = 1'b0;

    send(32'h4000, 4'd15, 3'd2, 2'b01);
    repeat (3) @(posedge aclk);
    #2;
    areset_n = 1'b0;
    #1;
    chk("midrst_beat_valid", {63'd0, bus_if.beat_valid}, 64'd0);
    chk("midrst_cmd_ready",  {63'd0, bus_if.cmd_ready}, 64'd1);
    chk("midrst_beat_idx",   {60'd0, bus_if.beat_idx}, 64'd0);
    chk("midrst_beat_addr",  {32'd0, bus_if.beat_addr}, 64'd0);
    @(posedge aclk);
    #1;
    areset_n = 1'b1;
    repeat (4) @(posedge aclk);
    #1;
    chk("postrst_cmd_ready", {63'd0, bus_if.cmd_ready}, 64'd1);

    stall_en = 1'b1;
    for (int t = 0; t < 80; t++) begin
      ra = $urandom;
      rl = 4'($urandom_range(0, 15));
      rs = 3'($urandom_range(0, 5));
      rb = 2'($urandom_range(0, 3));
      if (rb == 2'b10 && $urandom_range(0, 1) == 1) begin
        pick = $urandom_range(0, 3);
        rl   = (pick == 0) ? 4'd1 : (pick == 1) ? 4'd3 : (pick == 2) ? 4'd7 : 4'd15;
        rs   = 3'($urandom_range(0, 4));
        ra   = ra & ~((32'd1 << rs) - 32'd1);
      end
      send(ra, rl, rs, rb);
      if ($urandom_range(0, 2) == 0) wait_idle();
    end
    wait_idle();
    stall_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
